// File: rtl/int_fp_reg_file.sv
// Integer/floating-point register file: two 32-entry banks sharing one
// write-back index, four combinational read ports, optional same-cycle
// write-to-read forwarding, and asynchronous clear.
module int_fp_reg_file #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [4:0]        WB_rd_addr,
  input  logic [DATA_W-1:0] WB_rd_data,
  input  logic              f_reg_write,
  input  logic [DATA_W-1:0] frd_data,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [4:0]        frs1_addr,
  input  logic [4:0]        frs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] frs1_data,
  output logic [DATA_W-1:0] frs2_data
);

  logic [DATA_W-1:0] x_regs [32];
  logic [DATA_W-1:0] f_regs [32];

  logic bypass_on;
  logic int_fwd_1;
  logic int_fwd_2;
  logic fp_fwd_1;
  logic fp_fwd_2;

  assign bypass_on = (BYPASS_EN != 0);

  // Write-back into both banks; x0 is never stored, f0 is ordinary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        x_regs[i] <= '0;
        f_regs[i] <= '0;
      end
    end else begin
      if (reg_write && (WB_rd_addr != 5'd0)) begin
        x_regs[WB_rd_addr] <= WB_rd_data;
      end
      if (f_reg_write) begin
        f_regs[WB_rd_addr] <= frd_data;
      end
    end
  end

  // Forwarding hits are bank-local: integer writes only feed integer ports
  always_comb begin
    int_fwd_1 = bypass_on && reg_write   && (WB_rd_addr == rs1_addr);
    int_fwd_2 = bypass_on && reg_write   && (WB_rd_addr == rs2_addr);
    fp_fwd_1  = bypass_on && f_reg_write && (WB_rd_addr == frs1_addr);
    fp_fwd_2  = bypass_on && f_reg_write && (WB_rd_addr == frs2_addr);
  end

  // Integer reads: zero during reset and for index 0, else forwarded or stored
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (!rst) begin
      if (rs1_addr != 5'd0) begin
        rs1_data = int_fwd_1 ? WB_rd_data : x_regs[rs1_addr];
      end
      if (rs2_addr != 5'd0) begin
        rs2_data = int_fwd_2 ? WB_rd_data : x_regs[rs2_addr];
      end
    end
  end

  // Floating reads: zero during reset, else forwarded or stored (f0 included)
  always_comb begin
    frs1_data = '0;
    frs2_data = '0;
    if (!rst) begin
      frs1_data = fp_fwd_1 ? frd_data : f_regs[frs1_addr];
      frs2_data = fp_fwd_2 ? frd_data : f_regs[frs2_addr];
    end
  end

endmodule

// File: tb/tb_int_fp_reg_file.sv
// Directed bench: one instance with forwarding, one without, shared stimulus.
module tb_int_fp_reg_file;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  WB_rd_addr;
  logic [31:0] WB_rd_data;
  logic        f_reg_write;
  logic [31:0] frd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  frs1_addr;
  logic [4:0]  frs2_addr;
  logic [31:0] rs1_data, rs2_data, frs1_data, frs2_data;
  logic [31:0] nb_rs1_data, nb_rs2_data, nb_frs1_data, nb_frs2_data;

  int checks = 0;
  int errors = 0;

  int_fp_reg_file #(.DATA_W(32), .BYPASS_EN(1)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .WB_rd_addr(WB_rd_addr),
    .WB_rd_data(WB_rd_data), .f_reg_write(f_reg_write), .frd_data(frd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .frs1_addr(frs1_addr),
    .frs2_addr(frs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .frs1_data(frs1_data), .frs2_data(frs2_data)
  );

  int_fp_reg_file #(.DATA_W(32), .BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst(rst), .reg_write(reg_write), .WB_rd_addr(WB_rd_addr),
    .WB_rd_data(WB_rd_data), .f_reg_write(f_reg_write), .frd_data(frd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .frs1_addr(frs1_addr),
    .frs2_addr(frs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .frs1_data(nb_frs1_data), .frs2_data(nb_frs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; WB_rd_addr = '0; WB_rd_data = '0;
    f_reg_write = 1'b0; frd_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd31; frs1_addr = 5'd0; frs2_addr = 5'd31;
    tick();
    tick();

    // Reset values, and forwarding suppressed while rst is high
    reg_write = 1'b1; WB_rd_addr = 5'd5; WB_rd_data = 32'hCAFEF00D;
    f_reg_write = 1'b1; frd_data = 32'h0BADF00D; frs1_addr = 5'd5;
    #1;
    check("rst_x5_fwd", rs1_data, 32'h0);
    check("rst_x31", rs2_data, 32'h0);
    check("rst_f5_fwd", frs1_data, 32'h0);
    check("rst_f31", frs2_data, 32'h0);
    tick();
    rst = 1'b0; reg_write = 1'b0; f_reg_write = 1'b0; frs1_addr = 5'd0;
    #1;
    check("post_rst_x5", rs1_data, 32'h0);
    check("post_rst_f0", frs1_data, 32'h0);
    check("post_rst_x31", rs2_data, 32'h0);
    frs1_addr = 5'd5;
    #1;
    check("post_rst_f5", frs1_data, 32'h0);

    // Integer write x7 with same-cycle read
    reg_write = 1'b1; WB_rd_addr = 5'd7; WB_rd_data = 32'hDEADBEEF;
    rs1_addr = 5'd7; rs2_addr = 5'd7; frs1_addr = 5'd7;
    #1;
    check("x7_bypass_rs1", rs1_data, 32'hDEADBEEF);
    check("x7_bypass_rs2", rs2_data, 32'hDEADBEEF);
    check("x7_nobypass", nb_rs1_data, 32'h0);
    check("x7_not_to_fp", frs1_data, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("x7_stored", rs1_data, 32'hDEADBEEF);
    check("x7_stored_nb", nb_rs1_data, 32'hDEADBEEF);
    check("x7_not_in_f7", frs1_data, 32'h0);

    // x0 protection
    reg_write = 1'b1; WB_rd_addr = 5'd0; WB_rd_data = 32'h12345678; rs2_addr = 5'd0;
    #1;
    check("x0_same_cycle", rs2_data, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("x0_after_edge", rs2_data, 32'h0);
    check("x0_after_edge_nb", nb_rs2_data, 32'h0);

    // Dual-bank write to index 3
    reg_write = 1'b1; f_reg_write = 1'b1; WB_rd_addr = 5'd3;
    WB_rd_data = 32'h11; frd_data = 32'h3F800000;
    rs1_addr = 5'd3; frs1_addr = 5'd3; frs2_addr = 5'd3;
    #1;
    check("dual_x3_bypass", rs1_data, 32'h11);
    check("dual_f3_bypass", frs1_data, 32'h3F800000);
    check("dual_f3_nb_old", nb_frs1_data, 32'h0);
    tick();
    reg_write = 1'b0; f_reg_write = 1'b0;
    #1;
    check("dual_x3", rs1_data, 32'h11);
    check("dual_f3", frs1_data, 32'h3F800000);
    check("dual_f3_port2", frs2_data, 32'h3F800000);
    check("dual_x3_nb", nb_rs1_data, 32'h11);

    // Floating write must not forward into integer ports
    f_reg_write = 1'b1; WB_rd_addr = 5'd3; frd_data = 32'h40000000;
    #1;
    check("fp_not_to_int", rs1_data, 32'h11);
    check("fp_fwd_f3", frs2_data, 32'h40000000);
    f_reg_write = 1'b0;
    #1;

    // Back-to-back writes to f0
    f_reg_write = 1'b1; WB_rd_addr = 5'd0; frd_data = 32'h1; frs1_addr = 5'd0;
    #1;
    check("f0_fwd_1", frs1_data, 32'h1);
    check("f0_nb_old", nb_frs1_data, 32'h0);
    tick();
    frd_data = 32'h2;
    #1;
    check("f0_fwd_2", frs1_data, 32'h2);
    check("f0_nb_first", nb_frs1_data, 32'h1);
    tick();
    f_reg_write = 1'b0;
    #1;
    check("f0_last", frs1_data, 32'h2);
    check("f0_last_nb", nb_frs1_data, 32'h2);

    // Mid-cycle reset clears state and drops pending writes
    reg_write = 1'b1; WB_rd_addr = 5'd9; WB_rd_data = 32'hA5A5A5A5; rs1_addr = 5'd9;
    tick();
    reg_write = 1'b0;
    #1;
    check("x9_stored", rs1_data, 32'hA5A5A5A5);
    reg_write = 1'b1; WB_rd_data = 32'h5;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_x9", rs1_data, 32'h0);
    check("midrst_x9_nb", nb_rs1_data, 32'h0);
    check("midrst_f0", frs1_data, 32'h0);
    tick();
    WB_rd_data = 32'h77;
    #1;
    rst = 1'b0;
    #1;
    check("rel_fwd", rs1_data, 32'h77);
    check("rel_nb_cleared", nb_rs1_data, 32'h0);
    tick();
    reg_write = 1'b0; rs2_addr = 5'd7; frs2_addr = 5'd3;
    #1;
    check("rel_commit", rs1_data, 32'h77);
    check("rel_commit_nb", nb_rs1_data, 32'h77);
    check("x7_cleared", rs2_data, 32'h0);
    check("f3_cleared", frs2_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_fp_reg_file.md
INT_FP_REG_FILE -- requirements
Module: int_fp_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter BYPASS_EN, default 1, enabling same-cycle write-to-read forwarding.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port reg_write, input, 1, the integer-bank write enable from write-back.
REQ-006 The block SHALL have port WB_rd_addr, input, 5, the destination index for both banks.
REQ-007 The block SHALL have port WB_rd_data, input, DATA_W, the integer write data.
REQ-008 The block SHALL have port f_reg_write, input, 1, the floating-bank write enable from write-back.
REQ-009 The block SHALL have port frd_data, input, DATA_W, the floating write data.
REQ-010 The block SHALL have ports rs1_addr and rs2_addr, input, 5 each, the integer read indices from decode.
REQ-011 The block SHALL have ports frs1_addr and frs2_addr, input, 5 each, the floating read indices from decode.
REQ-012 The block SHALL have ports rs1_data and rs2_data, output, DATA_W each, the integer read data.
REQ-013 The block SHALL have ports frs1_data and frs2_data, output, DATA_W each, the floating read data.

Function
REQ-014 The block SHALL hold two banks of 32 x DATA_W registers: integer x0..x31 and floating f0..f31.
REQ-015 With reg_write=1 at a rising clk edge, the block SHALL write WB_rd_data into x[WB_rd_addr]; with WB_rd_addr=0 it SHALL discard the write.
REQ-016 With f_reg_write=1 at a rising clk edge, the block SHALL write frd_data into f[WB_rd_addr]; f0 is an ordinary writable register.
REQ-017 With reg_write and f_reg_write both 1 in one cycle, the block SHALL perform both writes independently to the same index in each bank.
REQ-018 The four read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-019 An integer read of index 0 SHALL return 0 unconditionally, including while a write to index 0 is presented.
REQ-020 With BYPASS_EN=1, reg_write=1, WB_rd_addr=rsN_addr and rsN_addr!=0, rsN_data SHALL return WB_rd_data in the same cycle.
REQ-021 With BYPASS_EN=1, f_reg_write=1 and WB_rd_addr=frsN_addr, frsN_data SHALL return frd_data in the same cycle; index 0 is included.
REQ-022 Forwarding SHALL be bank-local: an integer write SHALL never forward to a floating read port, and a floating write SHALL never forward to an integer read port.
REQ-023 With BYPASS_EN=0, reads SHALL return the stored value only; a write becomes visible from the cycle after the edge.
REQ-024 Two read ports with the same index SHALL return identical data in all cases.
REQ-025 The block SHALL have no handshake or stall: it accepts a write every cycle, and back-to-back writes to one index SHALL leave the last value.

Reset
REQ-026 While rst=1, all 64 registers SHALL be cleared to 0 immediately, independent of clk.
REQ-027 While rst=1, writes SHALL be ignored and all read outputs SHALL be 0, with forwarding suppressed.
REQ-028 Deassertion of rst SHALL take effect at the next rising clk edge; a write presented in that cycle SHALL be committed.
REQ-029 Assertion of rst between edges SHALL clear state immediately, and no pending write SHALL survive.

Verification
REQ-030 Reset then read: pulse rst, read x5, x31, f0 and f31 -> all four return 0x00000000.
REQ-031 Integer write then read: reg_write=1, WB_rd_addr=7, WB_rd_data=0xDEADBEEF, then rs1_addr=7 next cycle -> rs1_data=0xDEADBEEF; same-cycle read with BYPASS_EN=1 -> also 0xDEADBEEF.
REQ-032 x0 protection: write 0x12345678 to index 0 with rs2_addr=0 -> rs2_data=0 in the same cycle and after the edge.
REQ-033 Dual-bank write: reg_write=1 and f_reg_write=1, WB_rd_addr=3, WB_rd_data=0x11, frd_data=0x3F800000 -> x3=0x11 and f3=0x3F800000; rs1_addr=3 never shows 0x3F800000.
REQ-034 Mid-cycle reset: after writing x9=0xA5A5A5A5, assert rst between edges -> rs1_data for index 9 drops to 0 before the next edge.
REQ-035 Back-to-back writes: write f0=0x1, then f0=0x2 on consecutive cycles -> frs1_addr=0 returns 0x2 afterwards.
